uart_impl_top: RTL and testbench

FPGA top level that receives 8N1 UART bytes on uart_rxd and shows them on board LEDs. It contains a UART receiver sub-instance, i_uart_periph.i_uart_rx, which exposes the constants BIT_RATE, CLK_HZ, SAMPLES_PER_BIT and SAMPLES_THRESHOLD. Received bytes drive the green LEDs and a 4-deep RGB history. Slide switches select enable and display mode.

---
 rtl/uart_impl_top.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_impl_top.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_impl_top.sv
// 8N1 UART receiver top: received bytes drive a 4-deep RGB history and a
// switch-selected LED view (high/low nibble or receiver status).

module uart_rx #(
   parameter int BIT_RATE = 9600,
   parameter int CLK_HZ   = 50000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       rxd_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       busy_o,
   output logic [1:0] state_o
);

   localparam int CYCLES_PER_BIT    = CLK_HZ / BIT_RATE;
   localparam int SAMPLES_PER_BIT   = CYCLES_PER_BIT;
   localparam int SAMPLES_THRESHOLD = SAMPLES_PER_BIT / 2;
   localparam int STOP_CYCLES       = CYCLES_PER_BIT / 2;
   localparam int STOP_THRESHOLD    = STOP_CYCLES / 2;
   localparam int CNT_W             = $clog2(CYCLES_PER_BIT + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
   localparam logic [CNT_W-1:0] BIT_THR   = CNT_W'(SAMPLES_THRESHOLD);
   localparam logic [CNT_W-1:0] STOP_THR  = CNT_W'(STOP_THRESHOLD);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, rxs_q, prev_q;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] ones_sum;
   logic             win_last, sample_hi, fall;

   // Synchroniser and edge-detect flops preset to the idle-high line level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd_i;
         rxs_q   <= sync1_q;
         prev_q  <= rxs_q;
      end
   end

   assign ones_sum  = ones_q + {{(CNT_W-1){1'b0}}, rxs_q};
   assign win_last  = (state_q == S_STOP) ? (cyc_q == STOP_LAST) : (cyc_q == BIT_LAST);
   assign sample_hi = (state_q == S_STOP) ? (ones_sum > STOP_THR) : (ones_sum > BIT_THR);
   assign fall      = prev_q & ~rxs_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (fall) state_d = S_START;
         S_START: if (win_last) state_d = sample_hi ? S_IDLE : S_DATA;
         S_DATA:  if (win_last && (bit_q == 3'd7)) state_d = S_STOP;
         S_STOP:  if (win_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (!en_i) state_d = S_IDLE;
   end

   // Each window's ones count includes the sample taken on its last cycle.
   always_comb begin
      cyc_d   = cyc_q + 1'b1;
      ones_d  = ones_sum;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      valid_d = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            cyc_d  = '0;
            ones_d = '0;
         end
         S_START: begin
            if (win_last) begin
               cyc_d  = '0;
               ones_d = '0;
               bit_d  = 3'd0;
            end
         end
         S_DATA: begin
            if (win_last) begin
               cyc_d   = '0;
               ones_d  = '0;
               shreg_d = {sample_hi, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
            end
         end
         S_STOP: begin
            if (win_last && en_i) begin
               if (sample_hi) valid_d = 1'b1;
               else           err_d   = 1'b1;
            end
         end
         default: begin
            cyc_d  = '0;
            ones_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cyc_q   <= '0;
         ones_q  <= '0;
         bit_q   <= 3'd0;
         shreg_q <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         ones_q  <= ones_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign byte_o      = shreg_q;
   assign valid_o     = valid_q;
   assign frame_err_o = err_q;
   assign busy_o      = (state_q != S_IDLE);
   assign state_o     = state_q;

endmodule

module uart_periph #(
   parameter int BIT_RATE = 9600,
   parameter int CLK_HZ   = 50000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] sw_i,
   input  logic       rxd_i,
   output logic [2:0] rgb0_o,
   output logic [2:0] rgb1_o,
   output logic [2:0] rgb2_o,
   output logic [2:0] rgb3_o,
   output logic [3:0] led_o
);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_err, rx_busy;
   logic [1:0] rx_state;
   logic       unused_dbg;

   logic [7:0] last_q;
   logic [2:0] rgb0_q, rgb1_q, rgb2_q, rgb3_q;
   logic [1:0] cnt_q;
   logic [3:0] led_q, led_d;

   uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) i_uart_rx (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (sw_i[0]),
      .rxd_i       (rxd_i),
      .byte_o      (rx_byte),
      .valid_o     (rx_valid),
      .frame_err_o (rx_err),
      .busy_o      (rx_busy),
      .state_o     (rx_state)
   );

   assign unused_dbg = ^{sw_i[3], rx_state};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 8'h00;
         rgb0_q <= 3'd0;
         rgb1_q <= 3'd0;
         rgb2_q <= 3'd0;
         rgb3_q <= 3'd0;
         cnt_q  <= 2'd0;
      end else if (rx_valid) begin
         last_q <= rx_byte;
         rgb3_q <= rgb2_q;
         rgb2_q <= rgb1_q;
         rgb1_q <= rgb0_q;
         rgb0_q <= rx_byte[2:0];
         cnt_q  <= cnt_q + 2'd1;
      end
   end

   always_comb begin
      if (sw_i[2])      led_d = {rx_err, rx_busy, cnt_q};
      else if (sw_i[1]) led_d = last_q[3:0];
      else              led_d = last_q[7:4];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) led_q <= 4'h0;
      else         led_q <= led_d;
   end

   assign rgb0_o = rgb0_q;
   assign rgb1_o = rgb1_q;
   assign rgb2_o = rgb2_q;
   assign rgb3_o = rgb3_q;
   assign led_o  = led_q;

endmodule

module uart_impl_top #(
   parameter int BIT_RATE = 9600,
   parameter int CLK_HZ   = 50000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] sw,
   output logic [2:0] rgb0,
   output logic [2:0] rgb1,
   output logic [2:0] rgb2,
   output logic [2:0] rgb3,
   output logic [3:0] led,
   input  logic       uart_rxd
);

   uart_periph #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) i_uart_periph (
      .clk_i  (clk),
      .rst_ni (resetn),
      .sw_i   (sw),
      .rxd_i  (uart_rxd),
      .rgb0_o (rgb0),
      .rgb1_o (rgb1),
      .rgb2_o (rgb2),
      .rgb3_o (rgb3),
      .led_o  (led)
   );

endmodule

// File: tb/tb_uart_impl_top.sv
// Bench for uart_impl_top: UART frames in, RGB history and LED views checked
// against a byte-history model through an expected queue.

module tb_uart_impl_top;

   localparam int CPB = 10;
   localparam int W   = 12;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] sw;
   logic [2:0] rgb0, rgb1, rgb2, rgb3;
   logic [3:0] led;
   logic       uart_rxd;
   logic [W-1:0] rgb_all;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   logic [7:0] hist_m[4];
   logic [7:0] last_m;
   logic [1:0] cnt_m;
   logic       err_m;

   always #5 clk = ~clk;

   uart_impl_top #(.BIT_RATE(100000), .CLK_HZ(1000000)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .sw       (sw),
      .rgb0     (rgb0),
      .rgb1     (rgb1),
      .rgb2     (rgb2),
      .rgb3     (rgb3),
      .led      (led),
      .uart_rxd (uart_rxd)
   );

   assign rgb_all = {rgb0, rgb1, rgb2, rgb3};

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_rgb();
      return {hist_m[0][2:0], hist_m[1][2:0], hist_m[2][2:0], hist_m[3][2:0]};
   endfunction

   function automatic logic [3:0] model_led(input logic [3:0] s);
      if (s[2])      return {err_m, 1'b0, cnt_m};
      else if (s[1]) return last_m[3:0];
      else           return last_m[7:4];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) hist_m[i] = 8'h00;
      last_m = 8'h00;
      cnt_m  = 2'd0;
      err_m  = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      for (int i = 3; i > 0; i--) hist_m[i] = hist_m[i-1];
      hist_m[0] = b;
      last_m = b;
      cnt_m  = cnt_m + 2'd1;
      exp_q.push_back(model_rgb());
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      if (sw[0]) begin
         if (stop_ok) model_byte(b);
         else         err_m = 1'b1;
      end
      uart_rxd = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         wait_cycles(CPB);
      end
      uart_rxd = stop_ok;
      wait_cycles(CPB);
      if (!stop_ok) begin
         uart_rxd = 1'b1;
         wait_cycles(CPB);
      end
   endtask

   task automatic check_led(input string name);
      chk(name, {8'h00, led}, {8'h00, model_led(sw)});
   endtask

   // Each receiver valid pulse must be matched by an expected RGB snapshot,
   // compared once the history registers have taken the new byte.
   always @(negedge clk) begin
      if (resetn && dut.i_uart_periph.i_uart_rx.valid_o) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            chk("unexpected_byte", rgb_all, model_rgb());
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got valid pulse expected none at %0t", $time);
         end else begin
            chk("rgb_history", rgb_all, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] b;
      string s;
      s = "1B2C";
      resetn   = 1'b0;
      sw       = 4'b0011;
      uart_rxd = 1'b1;
      model_reset();
      wait_cycles(3);
      chk("reset_rgb0", {9'd0, rgb0}, 12'd0);
      chk("reset_rgb1", {9'd0, rgb1}, 12'd0);
      chk("reset_rgb2", {9'd0, rgb2}, 12'd0);
      chk("reset_rgb3", {9'd0, rgb3}, 12'd0);
      chk("reset_led",  {8'd0, led},  12'd0);
      chk("samples_per_bit", W'(dut.i_uart_periph.i_uart_rx.SAMPLES_PER_BIT), W'(10));
      chk("samples_threshold", W'(dut.i_uart_periph.i_uart_rx.SAMPLES_THRESHOLD), W'(5));
      resetn = 1'b1;
      wait_cycles(5);

      send_frame(8'h41, 1'b1);
      chk("A_rgb0", {9'd0, rgb0}, 12'd1);
      check_led("A_led_low");
      sw = 4'b0001;
      wait_cycles(2);
      check_led("A_led_high");
      sw = 4'b0011;

      for (int i = 0; i < 4; i++) send_frame(s[i], 1'b1);
      chk("b2b_rgb", rgb_all, {3'b011, 3'b010, 3'b010, 3'b001});

      send_frame(8'h00, 1'b1);
      chk("zero_rgb0", {9'd0, rgb0}, 12'd0);
      check_led("zero_led");
      sw = 4'b0111;
      wait_cycles(2);
      check_led("zero_status");

      uart_rxd = 1'b0;
      wait_cycles(3);
      uart_rxd = 1'b1;
      wait_cycles(3);
      chk("glitch_busy", {8'd0, led}, {8'd0, err_m, 1'b1, cnt_m});
      wait_cycles(20);
      check_led("glitch_idle");
      chk("glitch_rgb", rgb_all, model_rgb());

      sw = 4'b0011;
      send_frame(8'h55, 1'b0);
      sw = 4'b0111;
      wait_cycles(2);
      check_led("ferr_status");
      chk("ferr_rgb", rgb_all, model_rgb());
      sw = 4'b0011;
      wait_cycles(2);
      send_frame(8'h61, 1'b1);
      chk("a_rgb0", {9'd0, rgb0}, 12'd1);

      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom_range(0, 255));
         sw = {1'b0, 2'($urandom_range(0, 3)), 1'b1};
         send_frame(b, 1'b1);
         check_led("rand_led");
         wait_cycles($urandom_range(0, 3));
      end
      chk("rand_rgb", rgb_all, model_rgb());

      sw = 4'b0010;
      wait_cycles(2);
      send_frame(8'h7E, 1'b1);
      wait_cycles(5);
      chk("disabled_rgb", rgb_all, model_rgb());
      sw = 4'b0011;
      wait_cycles(2);

      uart_rxd = 1'b0;
      wait_cycles(CPB);
      b = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         uart_rxd = b[i];
         wait_cycles(CPB);
      end
      resetn = 1'b0;
      #1;
      model_reset();
      chk("midreset_rgb", rgb_all, 12'd0);
      chk("midreset_led", {8'd0, led}, 12'd0);
      uart_rxd = 1'b1;
      wait_cycles(3);
      resetn = 1'b1;
      wait_cycles(150);
      chk("postreset_rgb", rgb_all, 12'd0);
      chk("postreset_led", {8'd0, led}, 12'd0);

      chk("pending_expected", W'(exp_q.size()), W'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

endmodule
